// File: rtl/lcd_bus_master.sv
// CPU-side initiator for an HD44780-style LCD bus: buffers {rs,byte} writes in a FIFO
// and drains each entry by polling the busy flag and then issuing one write cycle.
module lcd_bus_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1,
    parameter int E_CYC      = 2,
    parameter int HOLD_CYC   = 1,
    parameter int POLL_MAX   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_strobe,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       idle,
    output logic       overflow,
    output logic       timeout,
    output logic       lcd_en,
    output logic       lcd_rnw,
    output logic       lcd_rs,
    inout  wire  [7:0] lcd_data
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int POLL_W  = $clog2(POLL_MAX + 1);
    localparam int MAX_CYC = (SETUP_CYC > E_CYC) ?
                             ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                             ((E_CYC > HOLD_CYC) ? E_CYC : HOLD_CYC);
    localparam int PH_W    = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        P_SETUP,
        P_E,
        P_HOLD,
        W_SETUP,
        W_E,
        W_HOLD
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [8:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic               full_q;
    logic               empty_q;
    logic               push;
    logic               pop;
    logic [8:0]         head;

    logic [PH_W-1:0]    ph_cnt;
    logic [PH_W-1:0]    ph_nxt;
    logic [PH_W-1:0]    ph_last;
    logic               ph_done;
    logic [POLL_W-1:0]  poll_cnt;
    logic [POLL_W-1:0]  poll_nxt;
    logic               busy_q;
    logic               sample;
    logic               latch;
    logic               timeout_nxt;
    logic               rs_q;
    logic [7:0]         data_q;
    logic               drive;
    logic               status_unused;

    assign push = wr_strobe && !full_q;
    assign head = mem[rd_ptr];
    assign full = full_q;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_nxt;
            full_q  <= (count_nxt == CNT_W'(FIFO_DEPTH));
            empty_q <= (count_nxt == '0);
            if (wr_strobe && full_q) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_rs, wr_data};
        end
    end

    always_comb begin
        ph_last = '0;
        case (state)
            P_SETUP, W_SETUP: ph_last = PH_W'(SETUP_CYC - 1);
            P_E, W_E:         ph_last = PH_W'(E_CYC - 1);
            P_HOLD, W_HOLD:   ph_last = PH_W'(HOLD_CYC - 1);
            default:          ph_last = '0;
        endcase
    end

    assign ph_done = (ph_cnt == ph_last);

    always_comb begin
        state_nxt   = state;
        ph_nxt      = ph_cnt;
        poll_nxt    = poll_cnt;
        pop         = 1'b0;
        timeout_nxt = 1'b0;
        sample      = 1'b0;
        latch       = 1'b0;
        if (state != IDLE) begin
            ph_nxt = ph_done ? '0 : ph_cnt + 1'b1;
        end
        case (state)
            IDLE: begin
                ph_nxt = '0;
                if (!empty_q) begin
                    state_nxt = P_SETUP;
                    poll_nxt  = '0;
                end
            end
            P_SETUP: begin
                if (ph_done) state_nxt = P_E;
            end
            P_E: begin
                if (ph_done) begin
                    sample    = 1'b1;
                    state_nxt = P_HOLD;
                end
            end
            P_HOLD: begin
                if (ph_done) begin
                    if (!busy_q) begin
                        latch     = 1'b1;
                        state_nxt = W_SETUP;
                    end else if (poll_cnt != POLL_W'(POLL_MAX)) begin
                        poll_nxt  = poll_cnt + 1'b1;
                        state_nxt = P_SETUP;
                    end else begin
                        // Display never went ready: discard this entry and move on.
                        pop         = 1'b1;
                        timeout_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            W_SETUP: begin
                if (ph_done) state_nxt = W_E;
            end
            W_E: begin
                if (ph_done) state_nxt = W_HOLD;
            end
            W_HOLD: begin
                if (ph_done) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph_cnt   <= '0;
            poll_cnt <= '0;
            busy_q   <= 1'b0;
            timeout  <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state    <= state_nxt;
            ph_cnt   <= ph_nxt;
            poll_cnt <= poll_nxt;
            timeout  <= timeout_nxt;
            if (sample) begin
                busy_q <= lcd_data[7];
            end
            if (latch) begin
                rs_q   <= head[8];
                data_q <= head[7:0];
            end
        end
    end

    // Only the busy flag matters; the address counter bits are ignored.
    assign status_unused = ^lcd_data[6:0];

    assign drive    = (state == W_SETUP) || (state == W_E) || (state == W_HOLD);
    assign lcd_en   = (state == P_E) || (state == W_E);
    assign lcd_rnw  = !drive;
    assign lcd_rs   = drive ? rs_q : 1'b0;
    assign lcd_data = drive ? data_q : 8'bz;
    assign idle     = empty_q && (state == IDLE);

endmodule
